// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//   Classifies debounced button gestures into short, double and long presses.
//   The input is the one-cycle edge pulses from a per-button debouncer. Each
//   gesture produces at most one event pulse.
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous reset, active-low
//   btn_ondn   in   debouncer 1->0 edge pulse (one cycle)
//   btn_onup   in   debouncer 0->1 edge pulse (one cycle)
//   evt_short  out  one-cycle pulse: single short press completed
//   evt_double out  one-cycle pulse: double press completed
//   evt_long   out  one-cycle pulse: press held LONG_CYCLES
//   held       out  level: long press active, button not yet released
//   busy       out  level: gesture in progress (state != IDLE)
// -----------------------------------------------------------------------------
module button_event_decoder #(
  parameter int unsigned LONG_CYCLES   = 250_000_000,
  parameter int unsigned DCLICK_CYCLES = 15_000_000,
  parameter bit          PRESS_ON_DN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_ondn,
  input  logic btn_onup,
  output logic evt_short,
  output logic evt_double,
  output logic evt_long,
  output logic held,
  output logic busy
);

  localparam int unsigned MAX_CYCLES = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES
                                                                     : DCLICK_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Elaboration-time parameter sanity check
  if (LONG_CYCLES < 2 || DCLICK_CYCLES < 2) begin : g_param_check
    $error("button_event_decoder: LONG_CYCLES and DCLICK_CYCLES must both be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dbl_pend;

  logic press_raw;
  logic release_raw;
  logic press_evt;
  logic release_evt;

  // Map debouncer edges onto press/release according to button polarity
  assign press_raw   = PRESS_ON_DN ? btn_ondn : btn_onup;
  assign release_raw = PRESS_ON_DN ? btn_onup : btn_ondn;

  // A press and release in the same cycle cancel each other out
  assign press_evt   = press_raw & ~release_raw;
  assign release_evt = release_raw & ~press_raw;

  // Gesture FSM with registered outputs; busy tracks the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dbl_pend   <= 1'b0;
      evt_short  <= 1'b0;
      evt_double <= 1'b0;
      evt_long   <= 1'b0;
      held       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Event pulses default low; the double event is delivered one cycle
      // after the second release via dbl_pend.
      evt_short  <= 1'b0;
      evt_long   <= 1'b0;
      evt_double <= dbl_pend;
      dbl_pend   <= 1'b0;

      case (state)
        IDLE: begin
          if (press_evt) begin
            state <= PRESS1;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        PRESS1: begin
          if (release_evt) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state    <= LONG_HELD;
            cnt      <= '0;
            evt_long <= 1'b1;
            held     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        WAIT2: begin
          if (press_evt) begin
            state <= PRESS2;
            cnt   <= '0;
          end else if (cnt == DCLICK_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            evt_short <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        PRESS2: begin
          if (release_evt) begin
            state    <= IDLE;
            cnt      <= '0;
            dbl_pend <= 1'b1;
            busy     <= 1'b0;
          end else if (cnt == LONG_LAST) begin
            // Holding the second press turns the gesture into a long press
            state    <= LONG_HELD;
            cnt      <= '0;
            evt_long <= 1'b1;
            held     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        LONG_HELD: begin
          if (release_evt) begin
            state <= IDLE;
            cnt   <= '0;
            held  <= 1'b0;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          held  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
//   Directed gestures against button_event_decoder (LONG=8, DCLICK=4).
//   Stimulus pushes expected events (kind + edge number) into a queue; a
//   monitor on the falling edge pops and compares whenever an event fires.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

  localparam int unsigned LONG_CYCLES   = 8;
  localparam int unsigned DCLICK_CYCLES = 4;

  localparam int K_SHORT  = 1;
  localparam int K_DOUBLE = 2;
  localparam int K_LONG   = 3;

  typedef struct {
    int kind;
    int cyc;
  } exp_evt_t;

  logic clk;
  logic rst_n;
  logic btn_ondn;
  logic btn_onup;
  logic evt_short;
  logic evt_double;
  logic evt_long;
  logic held;
  logic busy;

  int cyc;
  int n_cmp;
  int n_err;
  exp_evt_t exp_q[$];

  button_event_decoder #(
    .LONG_CYCLES  (LONG_CYCLES),
    .DCLICK_CYCLES(DCLICK_CYCLES),
    .PRESS_ON_DN  (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_ondn  (btn_ondn),
    .btn_onup  (btn_onup),
    .evt_short (evt_short),
    .evt_double(evt_double),
    .evt_long  (evt_long),
    .held      (held),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after posedge n, cyc == n
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, expv, cyc);
    end
  endtask

  // Drive one edge with the given pulses; returns that edge's number
  task automatic drive(input logic dn, input logic up, output int t);
    btn_ondn = dn;
    btn_onup = up;
    @(posedge clk);
    #1;
    btn_ondn = 1'b0;
    btn_onup = 1'b0;
    t = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input int kind, input int at);
    exp_evt_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    int nhigh;
    int kind;
    exp_evt_t e;
    nhigh = int'(evt_short) + int'(evt_double) + int'(evt_long);
    if (nhigh != 0) begin
      chk("evt_exclusive", nhigh, 1);
      kind = evt_short ? K_SHORT : (evt_double ? K_DOUBLE : K_LONG);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_evt: got kind %0d at edge %0d, expected none", kind, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("evt_kind", kind, e.kind);
        chk("evt_edge", cyc, e.cyc);
      end
    end
  end

  initial begin
    int t0;
    int t;
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    btn_ondn = 1'b0;
    btn_onup = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_held", int'(held), 0);
    chk("reset_evts", int'({evt_short, evt_double, evt_long}), 0);
    rst_n = 1'b1;
    idle(2);

    // 1: short press
    drive(1'b1, 1'b0, t0);
    chk("short_busy_on", int'(busy), 1);
    idle(2);
    drive(1'b0, 1'b1, t);
    expect_evt(K_SHORT, t0 + 7);
    idle(3);
    chk("short_busy_before", int'(busy), 1);
    idle(1);
    chk("short_busy_after", int'(busy), 0);
    idle(10);

    // 2: double press
    drive(1'b1, 1'b0, t0);
    idle(1);
    drive(1'b0, 1'b1, t);
    idle(1);
    drive(1'b1, 1'b0, t);
    idle(1);
    drive(1'b0, 1'b1, t);
    expect_evt(K_DOUBLE, t0 + 7);
    chk("double_busy_release", int'(busy), 0);
    idle(10);

    // 3: long press
    drive(1'b1, 1'b0, t0);
    expect_evt(K_LONG, t0 + 8);
    idle(7);
    chk("long_held_before", int'(held), 0);
    idle(1);
    chk("long_held_at", int'(held), 1);
    idle(11);
    chk("long_held_still", int'(held), 1);
    drive(1'b0, 1'b1, t);
    chk("long_held_release", int'(held), 0);
    chk("long_busy_release", int'(busy), 0);
    idle(10);

    // 4: short then long
    drive(1'b1, 1'b0, t0);
    drive(1'b0, 1'b1, t);
    idle(1);
    drive(1'b1, 1'b0, t);
    expect_evt(K_LONG, t0 + 11);
    idle(9);
    chk("shortlong_held", int'(held), 1);
    drive(1'b0, 1'b1, t);
    chk("shortlong_held_release", int'(held), 0);
    idle(10);

    // 5: reset mid-gesture
    drive(1'b1, 1'b0, t0);
    idle(2);
    rst_n = 1'b0;
    idle(1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_held", int'(held), 0);
    rst_n = 1'b1;
    idle(2);
    drive(1'b0, 1'b1, t);
    chk("midrst_release_ignored", int'(busy), 0);
    idle(15);

    // 6a: simultaneous press and release in IDLE
    drive(1'b1, 1'b1, t);
    chk("both_idle_busy", int'(busy), 0);
    idle(15);

    // 6b: repeated press in PRESS1 does not restart the count
    drive(1'b1, 1'b0, t0);
    idle(3);
    drive(1'b1, 1'b0, t);
    expect_evt(K_LONG, t0 + 8);
    idle(5);
    chk("repress_held", int'(held), 1);
    drive(1'b0, 1'b1, t);
    idle(10);

    // Every expected event must have been consumed
    chk("pending_evts", exp_q.size(), 0);
    while (exp_q.size() != 0) begin
      exp_evt_t e;
      e = exp_q.pop_front();
      $display("FAIL missing_evt: got none, expected kind %0d at edge %0d", e.kind, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
